// File: rtl/match_controller_if.sv
// Pong match-flow bus: player/frame events into the controller, ball gating and HUD state out.
interface match_controller_if;
   logic       timing_tick;
   logic       start;
   logic       pause;
   logic       point_p1;
   logic       point_p2;
   logic       ball_en;
   logic       ball_rst;
   logic       serve_dir;
   logic [3:0] player1_score;
   logic [3:0] player2_score;
   logic       game_over;
   logic       winner;
   logic [2:0] state_o;

   modport master (
      output timing_tick, start, pause, point_p1, point_p2,
      input  ball_en, ball_rst, serve_dir, player1_score, player2_score,
             game_over, winner, state_o
   );

   modport slave (
      input  timing_tick, start, pause, point_p1, point_p2,
      output ball_en, ball_rst, serve_dir, player1_score, player2_score,
             game_over, winner, state_o
   );
endinterface

// File: rtl/match_controller.sv
// Pong game-flow FSM: idle -> serve countdown -> rally -> point -> game over.
// Owns the scores and gates the ball datapath; every output is registered.
module match_controller #(
   parameter int WIN_SCORE         = 9,
   parameter int SERVE_DELAY_TICKS = 60
) (
   input  logic               clk,
   input  logic               rst,
   match_controller_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam logic [3:0] WIN   = 4'(WIN_SCORE);
   localparam logic [7:0] DELAY = 8'(SERVE_DELAY_TICKS);

   state_t     state, state_n;
   logic [3:0] p1, p1_n, p2, p2_n;
   logic [7:0] cnt, cnt_n;
   logic       dir, dir_n, go, go_n, win, win_n;
   logic       start_q, ball_en, ball_rst;
   logic       start_rise;

   assign start_rise = bus.start & ~start_q;

   always_comb begin
      state_n = state;
      p1_n    = p1;
      p2_n    = p2;
      cnt_n   = cnt;
      dir_n   = dir;
      go_n    = go;
      win_n   = win;
      case (state)
         S_IDLE, S_OVER: begin
            if (start_rise) begin
               p1_n    = '0;
               p2_n    = '0;
               dir_n   = 1'b0;
               go_n    = 1'b0;
               win_n   = 1'b0;
               cnt_n   = DELAY;
               state_n = S_SERVE;
            end
         end
         S_SERVE: begin
            if (bus.timing_tick && !bus.pause) begin
               if (cnt == 8'd1) state_n = S_PLAY;
               else             cnt_n   = cnt - 8'd1;
            end
         end
         S_PLAY: begin
            // a simultaneous double point replays the rally untouched
            if (bus.point_p1 && !bus.point_p2) begin
               p1_n  = p1 + 4'd1;
               dir_n = 1'b1;
            end else if (bus.point_p2 && !bus.point_p1) begin
               p2_n  = p2 + 4'd1;
               dir_n = 1'b0;
            end
            if (bus.point_p1 || bus.point_p2) state_n = S_POINT;
         end
         S_POINT: begin
            if (p1 == WIN || p2 == WIN) begin
               go_n    = 1'b1;
               win_n   = (p2 == WIN);
               state_n = S_OVER;
            end else begin
               cnt_n   = DELAY;
               state_n = S_SERVE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         p1       <= '0;
         p2       <= '0;
         cnt      <= '0;
         dir      <= 1'b0;
         go       <= 1'b0;
         win      <= 1'b0;
         start_q  <= 1'b0;
         ball_en  <= 1'b0;
         ball_rst <= 1'b1;
      end else begin
         state    <= state_n;
         p1       <= p1_n;
         p2       <= p2_n;
         cnt      <= cnt_n;
         dir      <= dir_n;
         go       <= go_n;
         win      <= win_n;
         start_q  <= bus.start;
         // ball gating follows the state being entered so it lines up with state_o
         ball_en  <= (state_n == S_PLAY) & ~bus.pause;
         ball_rst <= (state_n != S_PLAY);
      end
   end

   assign bus.ball_en       = ball_en;
   assign bus.ball_rst      = ball_rst;
   assign bus.serve_dir     = dir;
   assign bus.player1_score = p1;
   assign bus.player2_score = p2;
   assign bus.game_over     = go;
   assign bus.winner        = win;
   assign bus.state_o       = state;
endmodule
